// File: rtl/perf_status_monitor_pkg.sv
// ---------------------------------------------------------------------------
// perf_status_pkg
// Shared types and helpers for the performance/status monitor.
//   state_t          : monitor FSM state (RUN plus three terminal states)
//   DEF_STAT_REGION  : default address nibble [31:28] that marks a status store
//   DEF_PASS_CODE    : default status word that means "test passed"
//   clog2_min1()     : index width helper that never returns 0
// ---------------------------------------------------------------------------
package perf_status_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2,
    TOUT = 2'd3
  } state_t;

  localparam logic [3:0]  DEF_STAT_REGION = 4'h1;
  localparam logic [31:0] DEF_PASS_CODE   = 32'h0000_0777;

  // A single-entry counter bank would otherwise get a zero-width index.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/perf_status_monitor_cntr.sv
// ---------------------------------------------------------------------------
// perf_cntr
// One unsigned event counter for the performance monitor.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears the count
//   clr     : synchronous clear, wins over inc/freeze
//   freeze  : when high the count holds regardless of inc
//   inc     : count one event this cycle
//   count   : current count value
// Parameters:
//   CNTR_W   : counter width
//   SATURATE : 1 = stick at all-ones, 0 = wrap to zero
// ---------------------------------------------------------------------------
module perf_cntr #(
  parameter int CNTR_W   = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              freeze,
  input  logic              inc,
  output logic [CNTR_W-1:0] count
);

  // Clear first, then count unless frozen. In saturating mode an all-ones
  // value simply holds; otherwise the natural modulo add wraps it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !freeze) begin
      if (SATURATE && (&count)) begin
        count <= count;
      end else begin
        count <= count + CNTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_status_monitor.sv
// ---------------------------------------------------------------------------
// perf_status_monitor
// Synthesizable performance counters plus end-of-test status detector and
// watchdog. Sits beside the CPU, snoops data-bus stores and counts events.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   clr_i              : synchronous clear of counters, watchdog and state
//   evt_i[NUM_EVT]     : per-cycle event strobes, evt_i[i-1] feeds counter i
//   st_we_i/addr/data  : snooped data-bus store command
//   rd_en_i, rd_addr_i : counter read request; index 0 is the cycle counter
//   rd_data_o          : read data, one cycle after the request
//   rd_valid_o         : read data valid
//   done_o             : any terminal state reached
//   pass_o / fail_o    : status store matched / did not match PASS_CODE
//   timeout_o          : watchdog expired before a status store
//   code_o             : captured status word (0 on timeout)
// ---------------------------------------------------------------------------
module perf_status_monitor
  import perf_status_pkg::*;
#(
  parameter int          NUM_EVT     = 4,
  parameter int          CNTR_W      = 32,
  parameter bit          SATURATE    = 1'b0,
  parameter logic [3:0]  STAT_REGION = DEF_STAT_REGION,
  parameter logic [31:0] PASS_CODE   = DEF_PASS_CODE,
  parameter int          TIMEOUT     = 1500,
  parameter int          TO_W        = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clr_i,
  input  logic [NUM_EVT-1:0]                  evt_i,
  input  logic                                st_we_i,
  input  logic [31:0]                         st_addr_i,
  input  logic [31:0]                         st_data_i,
  input  logic                                rd_en_i,
  input  logic [clog2_min1(NUM_EVT+1)-1:0]    rd_addr_i,
  output logic [CNTR_W-1:0]                   rd_data_o,
  output logic                                rd_valid_o,
  output logic                                done_o,
  output logic                                pass_o,
  output logic                                fail_o,
  output logic                                timeout_o,
  output logic [31:0]                         code_o
);

  localparam int IDX_W = clog2_min1(NUM_EVT + 1);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t            state;
  state_t            next_state;
  logic [31:0]       code_next;
  logic [TO_W-1:0]   wd;
  logic              run;
  logic              hit;
  logic              wd_expire;
  logic [NUM_EVT:0]  inc;
  logic [CNTR_W-1:0] cnt [0:NUM_EVT];
  logic [CNTR_W-1:0] rd_mux;
  logic              unused_addr;

  // Only the region nibble of the store address matters.
  assign unused_addr = ^st_addr_i[27:0];

  assign run       = (state == RUN);
  assign hit       = run && st_we_i && (st_addr_i[31:28] == STAT_REGION);
  assign wd_expire = WD_EN && run && (wd == WD_LAST);

  // Counter 0 counts every cycle; counter i follows evt_i[i-1].
  assign inc = {evt_i, 1'b1};

  // Counters freeze as soon as the FSM leaves RUN, so the transition
  // cycle itself is still counted.
  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cntr
    perf_cntr #(
      .CNTR_W   (CNTR_W),
      .SATURATE (SATURATE)
    ) u_cntr (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .clr    (clr_i),
      .freeze (!run),
      .inc    (inc[g]),
      .count  (cnt[g])
    );
  end

  // Watchdog advances only while running and stops at its limit, so it can
  // never wrap even if the FSM were somehow held in RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd <= '0;
    end else if (clr_i) begin
      wd <= '0;
    end else if (WD_EN && run && (wd != WD_LAST)) begin
      wd <= wd + TO_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next state and captured code. clr wins over everything; a status hit
  // wins over a watchdog expiry in the same cycle; terminal states stick.
  always_comb begin
    next_state = state;
    code_next  = code_o;
    if (clr_i) begin
      next_state = RUN;
      code_next  = '0;
    end else if (state == RUN) begin
      if (hit) begin
        next_state = (st_data_i == PASS_CODE) ? PASS : FAIL;
        code_next  = st_data_i;
      end else if (wd_expire) begin
        next_state = TOUT;
        code_next  = '0;
      end
    end
  end

  // Status outputs are registered alongside the state so they always equal
  // a decode of the current state without a combinational path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      done_o    <= 1'b0;
      code_o    <= '0;
    end else begin
      pass_o    <= (next_state == PASS);
      fail_o    <= (next_state == FAIL);
      timeout_o <= (next_state == TOUT);
      done_o    <= (next_state != RUN);
      code_o    <= code_next;
    end
  end

  // Read mux; indices beyond the counter bank return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_addr_i == IDX_W'(i)) begin
        rd_mux = cnt[i];
      end
    end
  end

  // The read samples the counters before this edge's update, which also
  // makes a read coinciding with clr return the pre-clear value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        rd_data_o <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_perf_status_monitor.sv
// ---------------------------------------------------------------------------
// tb_perf_status_monitor
// Self-checking bench for perf_status_monitor. Four instances share one set
// of stimulus: a default build, a TIMEOUT=20 build and two 8-bit counter
// builds (wrapping and saturating). A vector table covers counting, reads
// and the pass transition; hand sequences cover fail, timeout, overflow,
// clear and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_perf_status_monitor;
  import perf_status_pkg::*;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        clr     = 1'b0;
  logic [3:0]  evt     = '0;
  logic        st_we   = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        rd_en   = 1'b0;
  logic [2:0]  rd_addr = '0;

  logic [31:0] m_rd_data, t_rd_data, m_code, t_code, w_code, s_code;
  logic [7:0]  w_rd_data, s_rd_data;
  logic        m_rd_valid, m_done, m_pass, m_fail, m_tout;
  logic        t_rd_valid, t_done, t_pass, t_fail, t_tout;
  logic        w_rd_valid, w_done, w_pass, w_fail, w_tout;
  logic        s_rd_valid, s_done, s_pass, s_fail, s_tout;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  localparam logic [31:0] STAT_A = 32'h1000_0000;

  always #5 clk = ~clk;

  perf_status_monitor #(.NUM_EVT(4), .CNTR_W(32), .SATURATE(1'b0), .TIMEOUT(1500)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .evt_i(evt), .st_we_i(st_we),
    .st_addr_i(st_addr), .st_data_i(st_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(m_rd_data), .rd_valid_o(m_rd_valid), .done_o(m_done), .pass_o(m_pass),
    .fail_o(m_fail), .timeout_o(m_tout), .code_o(m_code));

  perf_status_monitor #(.NUM_EVT(4), .CNTR_W(32), .SATURATE(1'b0), .TIMEOUT(20)) u_tout (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .evt_i(evt), .st_we_i(st_we),
    .st_addr_i(st_addr), .st_data_i(st_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(t_rd_data), .rd_valid_o(t_rd_valid), .done_o(t_done), .pass_o(t_pass),
    .fail_o(t_fail), .timeout_o(t_tout), .code_o(t_code));

  perf_status_monitor #(.NUM_EVT(4), .CNTR_W(8), .SATURATE(1'b0), .TIMEOUT(1500)) u_wrap8 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .evt_i(evt), .st_we_i(st_we),
    .st_addr_i(st_addr), .st_data_i(st_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(w_rd_data), .rd_valid_o(w_rd_valid), .done_o(w_done), .pass_o(w_pass),
    .fail_o(w_fail), .timeout_o(w_tout), .code_o(w_code));

  perf_status_monitor #(.NUM_EVT(4), .CNTR_W(8), .SATURATE(1'b1), .TIMEOUT(1500)) u_sat8 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .evt_i(evt), .st_we_i(st_we),
    .st_addr_i(st_addr), .st_data_i(st_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid), .done_o(s_done), .pass_o(s_pass),
    .fail_o(s_fail), .timeout_o(s_tout), .code_o(s_code));

  typedef struct {
    logic [3:0]  evt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_done;
    logic        exp_pass;
    logic        exp_fail;
    logic        exp_tout;
    logic [31:0] exp_code;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [3:0] e, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic re, input logic [2:0] ra,
                              input logic ev, input logic [31:0] ed, input logic dn,
                              input logic ps, input logic fl, input logic to,
                              input logic [31:0] cd);
    vec_t v;
    v.evt = e; v.we = we; v.addr = a; v.data = d; v.rd_en = re; v.rd_addr = ra;
    v.exp_valid = ev; v.exp_data = ed; v.exp_done = dn; v.exp_pass = ps;
    v.exp_fail = fl; v.exp_tout = to; v.exp_code = cd;
    return v;
  endfunction

  task automatic apply_stimulus(input logic [3:0] e, input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic re, input logic [2:0] ra);
    evt = e; st_we = we; st_addr = a; st_data = d; rd_en = re; rd_addr = ra;
  endtask

  // One clock edge, then sample 1 ns later, away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_main_status(input string tag, input logic dn, input logic ps,
                                   input logic fl, input logic to, input logic [31:0] cd);
    check_output({tag, " done"},    m_done, dn);
    check_output({tag, " pass"},    m_pass, ps);
    check_output({tag, " fail"},    m_fail, fl);
    check_output({tag, " timeout"}, m_tout, to);
    check_output({tag, " code"},    m_code, cd);
  endtask

  task automatic do_reset();
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b0, 3'd0);
    clr   = 1'b0;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    // Vector table: 10 cycles of evt=0101 with reads, pass store, then
    // frozen-counter reads including out-of-range indices.
    for (int i = 0; i < 5; i++)
      vecs[i] = mk(4'b0101, 0, '0, '0, 0, 3'd0, 0, 32'd0, 0, 0, 0, 0, '0);
    vecs[5]  = mk(4'b0101, 0, '0, '0, 1, 3'd0, 1, 32'd5,  0, 0, 0, 0, '0);
    vecs[6]  = mk(4'b0101, 0, '0, '0, 0, 3'd0, 0, 32'd5,  0, 0, 0, 0, '0);
    vecs[7]  = mk(4'b0101, 0, '0, '0, 1, 3'd1, 1, 32'd7,  0, 0, 0, 0, '0);
    vecs[8]  = mk(4'b0101, 0, '0, '0, 0, 3'd0, 0, 32'd7,  0, 0, 0, 0, '0);
    vecs[9]  = mk(4'b0101, 0, '0, '0, 0, 3'd0, 0, 32'd7,  0, 0, 0, 0, '0);
    vecs[10] = mk(4'b0000, 1, STAT_A, 32'h777, 0, 3'd0, 0, 32'd7, 1, 1, 0, 0, 32'h777);
    vecs[11] = mk(4'b1111, 0, '0, '0, 1, 3'd1, 1, 32'd10, 1, 1, 0, 0, 32'h777);
    vecs[12] = mk(4'b1111, 0, '0, '0, 1, 3'd3, 1, 32'd10, 1, 1, 0, 0, 32'h777);
    vecs[13] = mk(4'b1111, 0, '0, '0, 1, 3'd2, 1, 32'd0,  1, 1, 0, 0, 32'h777);
    vecs[14] = mk(4'b1111, 0, '0, '0, 1, 3'd0, 1, 32'd11, 1, 1, 0, 0, 32'h777);
    vecs[15] = mk(4'b1111, 0, '0, '0, 1, 3'd5, 1, 32'd0,  1, 1, 0, 0, 32'h777);
    vecs[16] = mk(4'b1111, 0, '0, '0, 1, 3'd4, 1, 32'd0,  1, 1, 0, 0, 32'h777);
    vecs[17] = mk(4'b1111, 0, '0, '0, 1, 3'd1, 1, 32'd10, 1, 1, 0, 0, 32'h777);
    vecs[18] = mk(4'b1111, 0, '0, '0, 0, 3'd0, 0, 32'd10, 1, 1, 0, 0, 32'h777);
    vecs[19] = mk(4'b1111, 1, STAT_A, 32'hDEAD, 1, 3'd0, 1, 32'd11, 1, 1, 0, 0, 32'h777);
    vecs[20] = mk(4'b0000, 0, '0, '0, 1, 3'd7, 1, 32'd0,  1, 1, 0, 0, 32'h777);

    $display("[TB] reset and vector table");
    do_reset();
    check_main_status("reset", 0, 0, 0, 0, '0);
    check_output("reset rd_valid", m_rd_valid, 1'b0);
    check_output("reset rd_data",  m_rd_data,  32'd0);

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(vecs[i].evt, vecs[i].we, vecs[i].addr, vecs[i].data,
                     vecs[i].rd_en, vecs[i].rd_addr);
      cycle();
      check_output($sformatf("vec%0d rd_valid", i), m_rd_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d rd_data", i),  m_rd_data,  vecs[i].exp_data);
      check_main_status($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_pass,
                        vecs[i].exp_fail, vecs[i].exp_tout, vecs[i].exp_code);
    end

    $display("[TB] fail store and sticky terminal state");
    do_reset();
    apply_stimulus(4'b0000, 1'b1, 32'h2000_0004, 32'hDEAD, 1'b0, 3'd0);
    cycle();
    check_main_status("wrong region", 0, 0, 0, 0, '0);
    apply_stimulus(4'b0000, 1'b0, 32'h1000_0004, 32'hDEAD, 1'b0, 3'd0);
    cycle();
    check_main_status("no write strobe", 0, 0, 0, 0, '0);
    apply_stimulus(4'b0000, 1'b1, 32'h1000_0004, 32'hDEAD, 1'b0, 3'd0);
    cycle();
    check_main_status("fail store", 1, 0, 1, 0, 32'hDEAD);
    apply_stimulus(4'b0000, 1'b1, STAT_A, 32'h777, 1'b0, 3'd0);
    cycle();
    check_main_status("pass after fail", 1, 0, 1, 0, 32'hDEAD);

    $display("[TB] watchdog expiry");
    do_reset();
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b0, 3'd0);
    for (int k = 0; k < 19; k++) cycle();
    check_output("wd edge19 timeout", t_tout, 1'b0);
    check_output("wd edge19 done",    t_done, 1'b0);
    cycle();
    check_output("wd edge20 timeout", t_tout, 1'b1);
    check_output("wd edge20 done",    t_done, 1'b1);
    check_output("wd edge20 pass",    t_pass, 1'b0);
    check_output("wd edge20 code",    t_code, 32'd0);
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b1, 3'd0);
    cycle();
    check_output("wd cycle count valid", t_rd_valid, 1'b1);
    check_output("wd cycle count",       t_rd_data,  32'd20);

    $display("[TB] status hit on expiry cycle");
    do_reset();
    for (int k = 0; k < 19; k++) cycle();
    apply_stimulus(4'b0000, 1'b1, STAT_A, 32'h777, 1'b0, 3'd0);
    cycle();
    check_output("hit vs wd pass",    t_pass, 1'b1);
    check_output("hit vs wd timeout", t_tout, 1'b0);
    check_output("hit vs wd code",    t_code, 32'h777);

    $display("[TB] clear restarts watchdog");
    do_reset();
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b0, 3'd0);
    for (int k = 0; k < 15; k++) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int k = 0; k < 19; k++) cycle();
    check_output("clr wd edge19 timeout", t_tout, 1'b0);
    cycle();
    check_output("clr wd edge20 timeout", t_tout, 1'b1);

    $display("[TB] 8-bit overflow");
    do_reset();
    apply_stimulus(4'b0001, 1'b0, '0, '0, 1'b0, 3'd0);
    for (int k = 0; k < 300; k++) cycle();
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b1, 3'd1);
    cycle();
    check_output("wrap8 counter1", w_rd_data, 8'd44);
    check_output("sat8 counter1",  s_rd_data, 8'd255);
    check_output("main counter1",  m_rd_data, 32'd300);
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b1, 3'd0);
    cycle();
    check_output("wrap8 cycles", w_rd_data, 8'd45);
    check_output("sat8 cycles",  s_rd_data, 8'd255);

    $display("[TB] clear priority");
    do_reset();
    apply_stimulus(4'b1111, 1'b0, '0, '0, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) cycle();
    clr = 1'b1;
    apply_stimulus(4'b1111, 1'b1, STAT_A, 32'h777, 1'b1, 3'd1);
    cycle();
    clr = 1'b0;
    check_output("clr read in flight valid", m_rd_valid, 1'b1);
    check_output("clr read in flight data",  m_rd_data,  32'd3);
    check_main_status("clr with hit", 0, 0, 0, 0, '0);
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b1, 3'd1);
    cycle();
    check_output("post clr counter1", m_rd_data, 32'd0);
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b1, 3'd0);
    cycle();
    check_output("post clr cycles", m_rd_data, 32'd1);
    apply_stimulus(4'b0000, 1'b1, STAT_A, 32'hDEAD, 1'b0, 3'd0);
    cycle();
    check_main_status("fail before clr", 1, 0, 1, 0, 32'hDEAD);
    clr = 1'b1;
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b0, 3'd0);
    cycle();
    clr = 1'b0;
    check_main_status("clr from fail", 0, 0, 0, 0, '0);

    $display("[TB] asynchronous reset mid-operation");
    do_reset();
    apply_stimulus(4'b0000, 1'b1, STAT_A, 32'h777, 1'b0, 3'd0);
    cycle();
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b1, 3'd0);
    cycle();
    check_output("pre reset rd_valid", m_rd_valid, 1'b1);
    check_output("pre reset rd_data",  m_rd_data,  32'd1);
    check_main_status("pre reset", 1, 1, 0, 0, 32'h777);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async reset rd_valid", m_rd_valid, 1'b0);
    check_output("async reset rd_data",  m_rd_data,  32'd0);
    check_main_status("async reset", 0, 0, 0, 0, '0);
    #2;
    rst_n = 1'b1;
    apply_stimulus(4'b0000, 1'b0, '0, '0, 1'b1, 3'd0);
    cycle();
    check_output("after reset rd_valid", m_rd_valid, 1'b1);
    check_output("after reset cycles",   m_rd_data,  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/perf_status_monitor.md
Name: perf_status_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only performance counters and end-of-test checker.
- Counts NUM_EVT event strobes from the CPU (retire, branch predicted, branch mispredicted, …) and a free cycle counter.
- Detects the test-status store to the status region and runs a watchdog timeout.
- Sits beside the CPU in main: taps the data-bus command, exposes counters through a 1-cycle read port, and reports pass/fail/timeout on both FPGA and simulator.

Parameters:
- NUM_EVT, 4, number of event inputs; counters 1..NUM_EVT.
- CNTR_W, 32, counter width, 8..64.
- SATURATE, 0, 1 = counters stick at all-ones; 0 = counters wrap.
- STAT_REGION, 4'h1, value of st_addr_i[31:28] that marks a status store.
- PASS_CODE, 32'h777, status data meaning pass.
- TIMEOUT, 1500, watchdog limit in cycles; 0 disables the watchdog.
- TO_W, 32, watchdog counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear of counters, watchdog and state
- evt_i  in  NUM_EVT  per-cycle event strobes
- st_we_i  in  1  data-bus write strobe
- st_addr_i  in  32  data-bus command address
- st_data_i  in  32  data-bus write data
- rd_en_i  in  1  counter read request
- rd_addr_i  in  $clog2(NUM_EVT+1)  counter index; 0 = cycle counter
- rd_data_o  out  CNTR_W  read data
- rd_valid_o  out  1  read data valid
- done_o  out  1  test finished (any terminal state)
- pass_o  out  1  status store equalled PASS_CODE
- fail_o  out  1  status store carried another value
- timeout_o  out  1  watchdog expired
- code_o  out  32  captured status data; 0 on timeout

Behaviour:
- Reset (rst_ni low, asynchronous): all counters 0, watchdog 0, state RUN, and every output 0.
- FSM states: RUN, PASS, FAIL, TOUT. PASS, FAIL and TOUT are terminal; only rst_ni or clr_i return the FSM to RUN.
- Status hit condition: st_we_i && st_addr_i[31:28]==STAT_REGION, evaluated only in RUN.
  - On a hit, the next state is PASS if st_data_i==PASS_CODE, otherwise FAIL.
  - code_o <= st_data_i, registered in the same cycle.
- Watchdog:
  - In RUN with TIMEOUT!=0, the watchdog increments each cycle.
  - When the watchdog reaches TIMEOUT-1 and there is no status hit, the next state is TOUT and code_o <= 0.
  - A status hit and watchdog expiry in the same cycle: the hit wins.
- Outputs are registered decodes of the state:
  - pass_o = (state==PASS), fail_o = (state==FAIL), timeout_o = (state==TOUT).
  - done_o = any terminal state.
  - All assert 1 cycle after the triggering edge.
- Counting (only while state==RUN and clr_i==0):
  - cycle counter +1 every cycle.
  - counter i +1 when evt_i[i-1]==1.
  - The cycle on which the terminal transition is taken is still counted; counters freeze from the next cycle.
- Width and overflow: CNTR_W-bit unsigned. At all-ones, the counter wraps to 0 if SATURATE==0 and holds if SATURATE==1. The watchdog never wraps: it is compared before increment.
- clr_i:
  - Zeroes counters, watchdog and code_o, and sets the state to RUN.
  - Has priority over events, status hits and timeout in the same cycle.
  - Does not affect a read already in flight.
- Read port:
  - rd_en_i in cycle N gives rd_valid_o=1 and rd_data_o in cycle N+1.
  - rd_data_o is the counter value as of the start of cycle N, before that cycle's increment.
  - An index greater than NUM_EVT returns 0, with rd_valid_o still asserted.
  - Reads are allowed in every state.
  - When rd_en_i is 0, rd_valid_o=0 next cycle and rd_data_o holds its last value.
- Reset mid-operation: asynchronous return to the reset values regardless of state; any pending read is dropped (rd_valid_o=0).

Decomposition:
- Package perf_status_pkg:
  - state enum {RUN, PASS, FAIL, TOUT} as a 2-bit typedef.
  - localparam for the default STAT_REGION and PASS_CODE.
  - function clog2_min1, which returns at least 1 for the index width.
- Sub-module perf_cntr: one CNTR_W counter with inc, clr, freeze and SATURATE. Instantiate it NUM_EVT+1 times with a generate loop.
- The FSM, watchdog and read mux stay in the top module.

Test Plan:
- Drive evt_i=4'b0101 for 10 cycles, then a store of 32'h777 to 0x1000_0000 → pass_o=1 and done_o=1 one cycle later; code_o=32'h777; counter1=10, counter3=10, counter2=0; cycle counter frozen thereafter.
- Store 32'hDEAD to 0x1000_0004 → fail_o=1, code_o=32'hDEAD; a later store of 32'h777 leaves the state FAIL.
- TIMEOUT=20 with no status store → timeout_o=1 on cycle 20 after reset release; code_o=0. Separately, a status hit on the expiry cycle → pass_o=1 and timeout_o=0.
- CNTR_W=8, evt_i[0] held for 300 cycles → SATURATE=0 reads 44; SATURATE=1 reads 255.
- rd_en_i with rd_addr_i=0 on cycle 5 after reset → rd_valid_o on cycle 6 with the pre-increment value. rd_addr_i=NUM_EVT+1 → data 0 and valid=1.
- Assert clr_i in the same cycle as an event and a status hit → all counters 0 and state RUN. Pulse rst_ni low mid-count (between clock edges) → all outputs 0 immediately.
